// File: rtl/mem_access.sv
// rv64IM memory-access stage: one 64-bit bus transaction per load/store,
// byte-lane steering, load extension, and registered write-back bundle.
module mem_access (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        valid_i,
  output logic        ready_o,
  input  logic        load_i,
  input  logic        store_i,
  input  logic [2:0]  funct3_i,
  input  logic [63:0] sdata_i,
  input  logic [63:0] aluout_i,
  input  logic        wen_i,
  input  logic [4:0]  rd_i,
  input  logic [63:0] pc_i,
  input  logic        exit_i,
  output logic        valid_o,
  output logic        wen_o,
  output logic [4:0]  rd_o,
  output logic [63:0] wbdata_o,
  output logic [63:0] pc_o,
  output logic        exit_o,
  output logic        err_o,
  output logic        req_o,
  output logic        we_o,
  output logic [63:0] addr_o,
  output logic [63:0] wdata_o,
  output logic [7:0]  wstrb_o,
  input  logic [63:0] rdata_i,
  input  logic        ack_i
);

  typedef enum logic {IDLE, BUS} state_t;

  state_t state, state_nxt;

  logic       accept;
  logic       is_mem;
  logic       illegal;
  logic       misal;
  logic       bad;
  logic       go_bus;
  logic       done;
  logic [2:0] off;
  logic [7:0] mask;

  logic        ld_q;
  logic        wen_q;
  logic [4:0]  rd_q;
  logic [63:0] pc_q;
  logic        exit_q;
  logic [2:0]  f3_q;
  logic [2:0]  off_q;
  logic [63:0] x;
  logic [63:0] ld_data;

  assign off     = aluout_i[2:0];
  assign ready_o = (state == IDLE);
  assign accept  = valid_i & ready_o;
  assign is_mem  = load_i | store_i;
  assign bad     = is_mem & (illegal | misal);
  assign go_bus  = accept & is_mem & ~bad;
  assign done    = (state == BUS) & ack_i;

  always_comb begin
    illegal = (load_i & store_i)
            | (load_i & (funct3_i == 3'b111))
            | (store_i & funct3_i[2]);
    misal = 1'b0;
    mask  = 8'h01;
    unique case (funct3_i[1:0])
      2'b00: begin misal = 1'b0;          mask = 8'h01; end
      2'b01: begin misal = off[0];        mask = 8'h03; end
      2'b10: begin misal = |off[1:0];     mask = 8'h0f; end
      2'b11: begin misal = |off;          mask = 8'hff; end
    endcase
  end

  always_comb begin
    x       = rdata_i >> {off_q, 3'b000};
    ld_data = x;
    unique case (f3_q)
      3'b000:  ld_data = {{56{x[7]}},  x[7:0]};
      3'b001:  ld_data = {{48{x[15]}}, x[15:0]};
      3'b010:  ld_data = {{32{x[31]}}, x[31:0]};
      3'b100:  ld_data = {56'd0, x[7:0]};
      3'b101:  ld_data = {48'd0, x[15:0]};
      3'b110:  ld_data = {32'd0, x[31:0]};
      default: ld_data = x;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    unique case (state)
      IDLE: if (go_bus) state_nxt = BUS;
      BUS:  if (ack_i)  state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      valid_o  <= 1'b0;
      wen_o    <= 1'b0;
      rd_o     <= '0;
      wbdata_o <= '0;
      pc_o     <= '0;
      exit_o   <= 1'b0;
      err_o    <= 1'b0;
      req_o    <= 1'b0;
      we_o     <= 1'b0;
      addr_o   <= '0;
      wdata_o  <= '0;
      wstrb_o  <= '0;
      ld_q     <= 1'b0;
      wen_q    <= 1'b0;
      rd_q     <= '0;
      pc_q     <= '0;
      exit_q   <= 1'b0;
      f3_q     <= '0;
      off_q    <= '0;
    end else begin
      valid_o <= 1'b0;
      if (accept) begin
        ld_q   <= load_i;
        wen_q  <= wen_i;
        rd_q   <= rd_i;
        pc_q   <= pc_i;
        exit_q <= exit_i;
        f3_q   <= funct3_i;
        off_q  <= off;
        if (go_bus) begin
          req_o   <= 1'b1;
          we_o    <= store_i;
          addr_o  <= {aluout_i[63:3], 3'b000};
          wdata_o <= store_i ? (sdata_i << {off, 3'b000}) : 64'd0;
          wstrb_o <= store_i ? (mask << off) : 8'd0;
        end else begin
          valid_o  <= 1'b1;
          err_o    <= bad;
          wen_o    <= wen_i & ~is_mem;
          wbdata_o <= aluout_i;
          rd_o     <= rd_i;
          pc_o     <= pc_i;
          exit_o   <= exit_i;
        end
      end
      if (done) begin
        req_o    <= 1'b0;
        we_o     <= 1'b0;
        wstrb_o  <= '0;
        valid_o  <= 1'b1;
        err_o    <= 1'b0;
        wen_o    <= ld_q & wen_q;
        wbdata_o <= ld_q ? ld_data : 64'd0;
        rd_o     <= rd_q;
        pc_o     <= pc_q;
        exit_o   <= exit_q;
      end
    end
  end

endmodule

// File: tb/tb_mem_access.sv
// Directed vector bench for mem_access: table of single bundles plus
// hand sequences for delayed ack, stray ack and mid-transaction reset.
module tb_mem_access;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        valid_i, ready_o;
  logic        load_i, store_i;
  logic [2:0]  funct3_i;
  logic [63:0] sdata_i, aluout_i;
  logic        wen_i;
  logic [4:0]  rd_i;
  logic [63:0] pc_i;
  logic        exit_i;
  logic        valid_o, wen_o;
  logic [4:0]  rd_o;
  logic [63:0] wbdata_o, pc_o;
  logic        exit_o, err_o;
  logic        req_o, we_o;
  logic [63:0] addr_o, wdata_o;
  logic [7:0]  wstrb_o;
  logic [63:0] rdata_i;
  logic        ack_i;

  int n_pass = 0;
  int n_total = 0;

  mem_access dut (
    .clk(clk), .rst_n(rst_n), .valid_i(valid_i), .ready_o(ready_o),
    .load_i(load_i), .store_i(store_i), .funct3_i(funct3_i),
    .sdata_i(sdata_i), .aluout_i(aluout_i), .wen_i(wen_i), .rd_i(rd_i),
    .pc_i(pc_i), .exit_i(exit_i), .valid_o(valid_o), .wen_o(wen_o),
    .rd_o(rd_o), .wbdata_o(wbdata_o), .pc_o(pc_o), .exit_o(exit_o),
    .err_o(err_o), .req_o(req_o), .we_o(we_o), .addr_o(addr_o),
    .wdata_o(wdata_o), .wstrb_o(wstrb_o), .rdata_i(rdata_i), .ack_i(ack_i)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic        ld;
    logic        st;
    logic [2:0]  f3;
    logic [63:0] sd;
    logic [63:0] alu;
    logic        wen;
    logic [4:0]  rd;
    logic [63:0] rdata;
    logic        mem;
    logic        err;
    logic        ewen;
    logic [63:0] ewb;
    logic [63:0] eaddr;
    logic [63:0] ewdata;
    logic [7:0]  ewstrb;
  } vec_t;

  vec_t vecs[14];

  task automatic chk(input string name, input logic [63:0] act,
                     input logic [63:0] exp);
    n_total++;
    if (act !== exp)
      $display("FAIL %s got=%h exp=%h", name, act, exp);
    else
      n_pass++;
  endtask

  task automatic run_vec(input vec_t v, input int idx);
    logic [63:0] pc;
    pc = 64'h1000_0000 + 64'(idx * 4);
    @(negedge clk);
    valid_i  = 1'b1;
    load_i   = v.ld;
    store_i  = v.st;
    funct3_i = v.f3;
    sdata_i  = v.sd;
    aluout_i = v.alu;
    wen_i    = v.wen;
    rd_i     = v.rd;
    pc_i     = pc;
    exit_i   = (idx == 12);
    @(posedge clk);
    #1;
    valid_i = 1'b0;
    if (v.mem) begin
      chk($sformatf("v%0d req", idx), 64'(req_o), 64'd1);
      chk($sformatf("v%0d we", idx), 64'(we_o), 64'(v.st));
      chk($sformatf("v%0d addr", idx), addr_o, v.eaddr);
      chk($sformatf("v%0d wstrb", idx), 64'(wstrb_o), 64'(v.ewstrb));
      chk($sformatf("v%0d wdata", idx), wdata_o, v.ewdata);
      chk($sformatf("v%0d busy", idx), 64'(ready_o), 64'd0);
      chk($sformatf("v%0d early", idx), 64'(valid_o), 64'd0);
      @(negedge clk);
      ack_i   = 1'b1;
      rdata_i = v.rdata;
      @(posedge clk);
      #1;
      ack_i = 1'b0;
    end
    chk($sformatf("v%0d valid", idx), 64'(valid_o), 64'd1);
    chk($sformatf("v%0d err", idx), 64'(err_o), 64'(v.err));
    chk($sformatf("v%0d wen", idx), 64'(wen_o), 64'(v.ewen));
    if (!v.err)
      chk($sformatf("v%0d wbdata", idx), wbdata_o, v.ewb);
    chk($sformatf("v%0d rd", idx), 64'(rd_o), 64'(v.rd));
    chk($sformatf("v%0d pc", idx), pc_o, pc);
    chk($sformatf("v%0d exit", idx), 64'(exit_o), 64'(idx == 12));
    chk($sformatf("v%0d noreq", idx), 64'(req_o), 64'd0);
    chk($sformatf("v%0d ready", idx), 64'(ready_o), 64'd1);
    @(posedge clk);
    #1;
    chk($sformatf("v%0d pulse", idx), 64'(valid_o), 64'd0);
  endtask

  initial begin
    // ld st f3 sdata alu wen rd rdata | mem err ewen ewb eaddr ewdata ewstrb
    vecs[0]  = '{0, 0, 3'b000, 64'h0, 64'h1234, 1, 5'd5, 64'h0,
                 0, 0, 1, 64'h1234, 64'h0, 64'h0, 8'h00};
    vecs[1]  = '{1, 0, 3'b000, 64'h0, 64'h1003, 1, 5'd7,
                 64'h00000000_80000000,
                 1, 0, 1, 64'hFFFFFFFF_FFFFFF80, 64'h1000, 64'h0, 8'h00};
    vecs[2]  = '{0, 1, 3'b001, 64'hABCD, 64'h3006, 1, 5'd3, 64'h0,
                 1, 0, 0, 64'h0, 64'h3000, 64'hABCD0000_00000000, 8'hC0};
    vecs[3]  = '{0, 1, 3'b010, 64'h1, 64'h4002, 0, 5'd0, 64'h0,
                 0, 1, 0, 64'h0, 64'h0, 64'h0, 8'h00};
    vecs[4]  = '{1, 0, 3'b111, 64'h0, 64'h5000, 1, 5'd4, 64'h0,
                 0, 1, 0, 64'h0, 64'h0, 64'h0, 8'h00};
    vecs[5]  = '{1, 1, 3'b011, 64'h0, 64'h6000, 1, 5'd6, 64'h0,
                 0, 1, 0, 64'h0, 64'h0, 64'h0, 8'h00};
    vecs[6]  = '{1, 0, 3'b101, 64'h0, 64'h1006, 1, 5'd8,
                 64'h87654321_00000000,
                 1, 0, 1, 64'h8765, 64'h1000, 64'h0, 8'h00};
    vecs[7]  = '{1, 0, 3'b010, 64'h0, 64'h1004, 1, 5'd9,
                 64'h80000000_00000000,
                 1, 0, 1, 64'hFFFFFFFF_80000000, 64'h1000, 64'h0, 8'h00};
    vecs[8]  = '{0, 1, 3'b011, 64'h01234567_89ABCDEF, 64'h2000, 0, 5'd0,
                 64'h0,
                 1, 0, 0, 64'h0, 64'h2000, 64'h01234567_89ABCDEF, 8'hFF};
    vecs[9]  = '{0, 1, 3'b100, 64'h0, 64'h10, 0, 5'd0, 64'h0,
                 0, 1, 0, 64'h0, 64'h0, 64'h0, 8'h00};
    vecs[10] = '{1, 0, 3'b011, 64'h0, 64'h8, 1, 5'd10,
                 64'hCAFEBABE_12345678,
                 1, 0, 1, 64'hCAFEBABE_12345678, 64'h8, 64'h0, 8'h00};
    vecs[11] = '{1, 0, 3'b001, 64'h0, 64'h1001, 1, 5'd11, 64'h0,
                 0, 1, 0, 64'h0, 64'h0, 64'h0, 8'h00};
    vecs[12] = '{0, 0, 3'b000, 64'h0, 64'h55, 1, 5'd0, 64'h0,
                 0, 0, 1, 64'h55, 64'h0, 64'h0, 8'h00};
    vecs[13] = '{1, 0, 3'b100, 64'h0, 64'h7, 1, 5'd12,
                 64'hFF000000_00000000,
                 1, 0, 1, 64'hFF, 64'h0, 64'h0, 8'h00};

    rst_n = 1'b0; valid_i = 1'b0; load_i = 1'b0; store_i = 1'b0;
    funct3_i = '0; sdata_i = '0; aluout_i = '0; wen_i = 1'b0;
    rd_i = '0; pc_i = '0; exit_i = 1'b0; rdata_i = '0; ack_i = 1'b0;

    repeat (2) @(posedge clk);
    #1;
    chk("rst ready", 64'(ready_o), 64'd1);
    chk("rst valid", 64'(valid_o), 64'd0);
    chk("rst req", 64'(req_o), 64'd0);
    chk("rst err", 64'(err_o), 64'd0);
    chk("rst wstrb", 64'(wstrb_o), 64'd0);
    chk("rst wbdata", wbdata_o, 64'd0);
    chk("rst addr", addr_o, 64'd0);
    @(negedge clk);
    rst_n = 1'b1;

    for (int i = 0; i < 14; i++)
      run_vec(vecs[i], i);

    // LWU with ack held off for three request cycles
    @(negedge clk);
    valid_i = 1'b1; load_i = 1'b1; store_i = 1'b0; funct3_i = 3'b110;
    aluout_i = 64'h2004; wen_i = 1'b1; rd_i = 5'd9; exit_i = 1'b0;
    @(posedge clk);
    #1;
    valid_i = 1'b0;
    for (int k = 0; k < 3; k++) begin
      chk($sformatf("lwu req c%0d", k), 64'(req_o), 64'd1);
      chk($sformatf("lwu addr c%0d", k), addr_o, 64'h2000);
      chk($sformatf("lwu ready c%0d", k), 64'(ready_o), 64'd0);
      chk($sformatf("lwu valid c%0d", k), 64'(valid_o), 64'd0);
      if (k < 2) begin
        @(posedge clk);
        #1;
      end
    end
    @(negedge clk);
    ack_i = 1'b1; rdata_i = 64'hDEADBEEF_00000000;
    @(posedge clk);
    #1;
    ack_i = 1'b0;
    chk("lwu done valid", 64'(valid_o), 64'd1);
    chk("lwu wbdata", wbdata_o, 64'h00000000_DEADBEEF);
    chk("lwu wen", 64'(wen_o), 64'd1);
    chk("lwu rd", 64'(rd_o), 64'd9);
    chk("lwu req off", 64'(req_o), 64'd0);

    // stray ack in IDLE
    @(negedge clk);
    ack_i = 1'b1;
    @(posedge clk);
    #1;
    ack_i = 1'b0;
    chk("stray valid", 64'(valid_o), 64'd0);
    chk("stray ready", 64'(ready_o), 64'd1);

    // reset colliding with ack during a pending LD
    @(negedge clk);
    valid_i = 1'b1; load_i = 1'b1; store_i = 1'b0; funct3_i = 3'b011;
    aluout_i = 64'h8; wen_i = 1'b1; rd_i = 5'd2;
    @(posedge clk);
    #1;
    valid_i = 1'b0;
    chk("rstbus req", 64'(req_o), 64'd1);
    @(posedge clk);
    #1;
    @(negedge clk);
    rst_n = 1'b0; ack_i = 1'b1; rdata_i = 64'h1111;
    @(posedge clk);
    #1;
    ack_i = 1'b0;
    chk("rstbus valid", 64'(valid_o), 64'd0);
    chk("rstbus req off", 64'(req_o), 64'd0);
    chk("rstbus ready", 64'(ready_o), 64'd1);
    @(negedge clk);
    rst_n = 1'b1;
    run_vec(vecs[0], 0);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule

// File: doc/mem_access.md
# mem_access

Memory-access stage of the rv64IM pipeline, sitting between the execute stage and write-back. It consumes the execute-stage bundle (ALU result, load/store flags, funct3, store data, rd/wen, pc, exit). For loads and stores it runs one transaction on the 64-bit data bus and produces byte-lane strobes and load sign/zero extension. Non-memory results pass through with one registered cycle of latency.

## Interface
No parameters; data bus width fixed at 64 bits, 8 byte lanes.
- clk  in  1  clock, all state updates on rising edge
- rst_n  in  1  reset, synchronous, active-low
- valid_i  in  1  execute bundle valid this cycle
- ready_o  out  1  stage can accept a bundle (high only in IDLE)
- load_i / store_i  in  1 each  access type from execute stage
- funct3_i  in  3  access size / signedness
- sdata_i  in  64  store data (rs2 value)
- aluout_i  in  64  effective address for load/store, else the result
- wen_i  in  1, rd_i  in  5, pc_i  in  64, exit_i  in  1  write-back/debug fields
- valid_o  out  1  write-back bundle valid (one-cycle pulse per bundle)
- wen_o  out  1, rd_o  out  5, wbdata_o  out  64, pc_o  out  64, exit_o  out  1
- err_o  out  1  misaligned or illegal access; qualifies valid_o
- req_o  out  1  bus request
- we_o  out  1  1 = store
- addr_o  out  64  {aluout_i[63:3], 3'b000}
- wdata_o  out  64  store data shifted to lane
- wstrb_o  out  8  byte-lane enables; 0 for loads
- rdata_i  in  64  load data, valid with ack_i
- ack_i  in  1  bus completion, single-cycle pulse

## Operation
- States: IDLE, BUS.
- Accept: valid_i & ready_o at an edge latches the whole bundle into internal registers.
- Non-memory bundles (load_i=0, store_i=0):
  - Stay in IDLE.
  - wbdata_o = aluout_i.
- Legality: load_i & store_i both high is illegal. Load funct3 111 is illegal. Store funct3 1xx is illegal.
- Alignment: size is 1/2/4/8 bytes from funct3[1:0]. Misaligned when addr[0]≠0 (H), addr[1:0]≠0 (W), or addr[2:0]≠0 (D).
- Illegal or misaligned bundles: no bus request, stay IDLE, err_o=1, wen_o=0.
- Legal load/store: go to BUS.
  - req_o, we_o, addr_o, wdata_o, wstrb_o are registered and held stable until ack_i.
  - On ack_i: return to IDLE.
- Store lanes:
  - wstrb_o = ({1,3,15,255}[size]) << addr[2:0].
  - wdata_o = sdata_i << (8·addr[2:0]).
  - wen_o forced 0.
- Load data: x = rdata_i >> (8·addr[2:0]), then by funct3:
  - 000 sext x[7:0]; 001 sext x[15:0]; 010 sext x[31:0]; 011 x.
  - 100 zext [7:0]; 101 zext [15:0]; 110 zext [31:0].
- rd=0 with wen_i=1 passes through unchanged; the register file ignores x0.
- ack_i while req_o=0 is ignored.
- The write-back side never backpressures.

## Timing
- Reset values: state IDLE, ready_o=1, valid_o=0, err_o=0, req_o=0, we_o=0, wstrb_o=0, all data/addr/rd/pc outputs 0, wen_o=0, exit_o=0.
- Non-memory, illegal, or misaligned bundle accepted at edge N: valid_o high for the cycle after N, with all fields.
- Memory bundle accepted at edge N:
  - req_o high from the cycle after N.
  - ack_i sampled high at edge M (M ≥ N+1) gives req_o low and valid_o high in cycle M+1.
  - Minimum load-to-valid latency is 2 cycles.
- ready_o is low throughout BUS. A new bundle can be accepted at edge M (the ack edge) only after that edge, i.e. from cycle M+1.
- valid_o is a single-cycle pulse; it drops unless a new bundle is completed.
- rst_n low at any edge, including mid-BUS: outputs return to reset values next cycle. The outstanding transaction is abandoned; the bus slave tolerates a dropped req_o.
- ack_i and rst_n low at the same edge: reset wins, no valid_o.

## Test plan
- ADD pass-through: aluout_i=0x1234, wen_i=1, rd_i=5, accepted at edge 0 → valid_o=1, wbdata_o=0x1234, rd_o=5 at cycle 1; req_o stays 0.
- LB at 0x1003, ack_i at the first req cycle with rdata_i=0x00000000_80000000 → addr_o=0x1000, wstrb_o=0; valid_o 2 cycles after accept with wbdata_o=0xFFFFFFFF_FFFFFF80.
- LWU at 0x2004, ack delayed 3 cycles, rdata_i=0xDEADBEEF_00000000 → req_o held 3 cycles with stable addr_o=0x2000 and ready_o=0 throughout; wbdata_o=0x00000000_DEADBEEF.
- SH at 0x3006, sdata_i=0xABCD → wstrb_o=0xC0, wdata_o=0xABCD0000_00000000, we_o=1; valid_o after ack with wen_o=0.
- SW at 0x4002 (misaligned), then LD funct3 111 (illegal) → both: no req_o, valid_o next cycle with err_o=1, wen_o=0.
- rst_n low two cycles into a pending LD with ack_i pulsed in the same cycle → no valid_o; req_o=0 and ready_o=1 the next cycle.
